// File: rtl/regfile_pkg.sv
// Shared types and constants for the multiport register file.
// Clear-sequencer state encoding and the hardwired-zero register address.
package regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int unsigned REG_ZERO = 0;

    function automatic int unsigned depth_of(input int unsigned nb_addr);
        return 32'd1 << nb_addr;
    endfunction

endpackage

// File: rtl/regfile_multiport_if.sv
// Write, read, debug and clear-control bundle of the multiport register file.
// The slave modport is the register file; the master modport is its driver.
interface regfile_multiport_if #(
    parameter int unsigned NB_REG  = 32,
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned N_RD    = 2
);

    logic                      i_enable;
    logic                      i_dunit_clk_en;
    logic                      i_wb_we;
    logic [NB_ADDR-1:0]        i_wb_addr;
    logic [NB_REG-1:0]         i_wb_data;
    logic [N_RD*NB_ADDR-1:0]   i_rd_addr;
    logic [N_RD*NB_REG-1:0]    o_rd_data;
    logic [NB_ADDR-1:0]        i_dbg_addr;
    logic [NB_REG-1:0]         o_dbg_data;
    logic                      i_clear;
    logic                      o_busy;
    logic                      o_clear_done;

    modport slave (
        input  i_enable, i_dunit_clk_en, i_wb_we, i_wb_addr, i_wb_data,
               i_rd_addr, i_dbg_addr, i_clear,
        output o_rd_data, o_dbg_data, o_busy, o_clear_done
    );

    modport master (
        output i_enable, i_dunit_clk_en, i_wb_we, i_wb_addr, i_wb_data,
               i_rd_addr, i_dbg_addr, i_clear,
        input  o_rd_data, o_dbg_data, o_busy, o_clear_done
    );

endinterface

// File: rtl/regfile_clear_seq.sv
// Soft-clear sequencer: walks every address once, zeroing it, then pulses done.
// Everything advances only on debug-unit clock-enable cycles.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int unsigned NB_ADDR = 5
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_dunit_clk_en,
    input  logic               i_clear,
    output logic               o_clr_we,
    output logic [NB_ADDR-1:0] o_clr_addr,
    output logic               o_idle,
    output logic               o_busy,
    output logic               o_clear_done
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = '1;

    state_t             r_state;
    logic [NB_ADDR-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (i_dunit_clk_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_clear) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    // Counter parks on the last address; only the DONE exit rewinds it.
                    if (r_cnt == LAST_ADDR) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + NB_ADDR'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clr_we     = (r_state == ST_CLEAR) && i_dunit_clk_en;
    assign o_clr_addr   = r_cnt;
    assign o_idle       = (r_state == ST_IDLE);
    assign o_busy       = r_busy;
    assign o_clear_done = r_done;

endmodule

// File: rtl/regfile_multiport.sv
// ID-stage register file: N_RD combinational read ports, one write port, a debug
// read port, optional hardwired R0, optional write-to-read bypass and soft clear.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned NB_REG   = 32,
    parameter int unsigned NB_ADDR  = 5,
    parameter int unsigned N_RD     = 2,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    regfile_multiport_if.slave   bus
);

    localparam int unsigned DEPTH = depth_of(NB_ADDR);

    logic [NB_REG-1:0]      r_mem [DEPTH];
    logic                   w_clr_we;
    logic [NB_ADDR-1:0]     w_clr_addr;
    logic                   w_idle;
    logic                   w_busy;
    logic                   w_clear_done;
    logic                   w_wr_zero;
    logic                   w_wr_ok;
    logic [N_RD*NB_REG-1:0] w_rd_data;
    logic [NB_REG-1:0]      w_dbg_data;

    regfile_clear_seq #(
        .NB_ADDR (NB_ADDR)
    ) u_clear_seq (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_dunit_clk_en (bus.i_dunit_clk_en),
        .i_clear        (bus.i_clear),
        .o_clr_we       (w_clr_we),
        .o_clr_addr     (w_clr_addr),
        .o_idle         (w_idle),
        .o_busy         (w_busy),
        .o_clear_done   (w_clear_done)
    );

    assign w_wr_zero = ZERO_REG && (bus.i_wb_addr == NB_ADDR'(REG_ZERO));
    assign w_wr_ok   = bus.i_wb_we && bus.i_enable && bus.i_dunit_clk_en
                       && w_idle && !w_wr_zero;

    // Clear and pipeline writes never coincide: w_wr_ok requires the sequencer idle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[bus.i_wb_addr] <= bus.i_wb_data;
        end
    end

    always_comb begin
        logic [NB_ADDR-1:0] w_addr;
        w_rd_data = '0;
        w_addr    = '0;
        for (int unsigned k = 0; k < N_RD; k++) begin
            w_addr = bus.i_rd_addr[k*NB_ADDR +: NB_ADDR];
            if (ZERO_REG && (w_addr == NB_ADDR'(REG_ZERO))) begin
                w_rd_data[k*NB_REG +: NB_REG] = '0;
            end else if (BYPASS && w_wr_ok && (w_addr == bus.i_wb_addr)) begin
                w_rd_data[k*NB_REG +: NB_REG] = bus.i_wb_data;
            end else begin
                w_rd_data[k*NB_REG +: NB_REG] = r_mem[w_addr];
            end
        end
    end

    // The debug dump must reflect stored state, so no forwarding here.
    always_comb begin
        w_dbg_data = r_mem[bus.i_dbg_addr];
        if (ZERO_REG && (bus.i_dbg_addr == NB_ADDR'(REG_ZERO))) begin
            w_dbg_data = '0;
        end
    end

    assign bus.o_rd_data    = w_rd_data;
    assign bus.o_dbg_data   = w_dbg_data;
    assign bus.o_busy       = w_busy;
    assign bus.o_clear_done = w_clear_done;

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: two instances (R0+bypass, and plain) share stimulus
// and are checked every cycle against an array-based model, plus directed literals.
module tb_regfile_multiport;

    localparam int unsigned NB_REG  = 32;
    localparam int unsigned NB_ADDR = 5;
    localparam int unsigned N_RD    = 2;
    localparam int unsigned DEPTH   = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_multiport_if #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .N_RD(N_RD)) ifa ();
    regfile_multiport_if #(.NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .N_RD(N_RD)) ifb ();

    assign ifb.i_enable       = ifa.i_enable;
    assign ifb.i_dunit_clk_en = ifa.i_dunit_clk_en;
    assign ifb.i_wb_we        = ifa.i_wb_we;
    assign ifb.i_wb_addr      = ifa.i_wb_addr;
    assign ifb.i_wb_data      = ifa.i_wb_data;
    assign ifb.i_rd_addr      = ifa.i_rd_addr;
    assign ifb.i_dbg_addr     = ifa.i_dbg_addr;
    assign ifb.i_clear        = ifa.i_clear;

    regfile_multiport #(
        .NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .N_RD(N_RD), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifa)
    );

    regfile_multiport #(
        .NB_REG(NB_REG), .NB_ADDR(NB_ADDR), .N_RD(N_RD), .ZERO_REG(1'b0), .BYPASS(1'b0)
    ) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .bus(ifb)
    );

    // Model: plain arrays plus a "clearing / done" flag and the next address to wipe.
    logic [31:0] m_a [DEPTH] = '{default: 32'd0};
    logic [31:0] m_b [DEPTH] = '{default: 32'd0};
    bit          m_clearing  = 1'b0;
    bit          m_done      = 1'b0;
    int unsigned m_pos       = 0;

    int total  = 0;
    int bad    = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_a[i] = 32'd0;
                m_b[i] = 32'd0;
            end
            m_clearing = 1'b0;
            m_done     = 1'b0;
            m_pos      = 0;
        end else if (ifa.i_dunit_clk_en) begin
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_clearing) begin
                m_a[m_pos] = 32'd0;
                m_b[m_pos] = 32'd0;
                if (m_pos == DEPTH - 1) begin
                    m_clearing = 1'b0;
                    m_done     = 1'b1;
                end else begin
                    m_pos++;
                end
            end else begin
                if (ifa.i_wb_we && ifa.i_enable) begin
                    if (ifa.i_wb_addr != 0) m_a[ifa.i_wb_addr] = ifa.i_wb_data;
                    m_b[ifa.i_wb_addr] = ifa.i_wb_data;
                end
                if (ifa.i_clear) begin
                    m_clearing = 1'b1;
                    m_pos      = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic        wr;
            logic [4:0]  ad;
            logic [31:0] ea;
            wr = ifa.i_wb_we && ifa.i_enable && ifa.i_dunit_clk_en && !m_clearing && !m_done;
            for (int k = 0; k < N_RD; k++) begin
                ad = ifa.i_rd_addr[k*NB_ADDR +: NB_ADDR];
                if (ad == 0)                          ea = 32'd0;
                else if (wr && ad == ifa.i_wb_addr)   ea = ifa.i_wb_data;
                else                                  ea = m_a[ad];
                chk($sformatf("rd%0d_a", k), ifa.o_rd_data[k*NB_REG +: NB_REG], ea);
                chk($sformatf("rd%0d_b", k), ifb.o_rd_data[k*NB_REG +: NB_REG], m_b[ad]);
            end
            chk("dbg_a", ifa.o_dbg_data, (ifa.i_dbg_addr == 0) ? 32'd0 : m_a[ifa.i_dbg_addr]);
            chk("dbg_b", ifb.o_dbg_data, m_b[ifa.i_dbg_addr]);
            chk("busy_a", 32'(ifa.o_busy), 32'(m_clearing));
            chk("busy_b", 32'(ifb.o_busy), 32'(m_clearing));
            chk("done_a", 32'(ifa.o_clear_done), 32'(m_done));
            chk("done_b", 32'(ifb.o_clear_done), 32'(m_done));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int k, input logic [4:0] a);
        ifa.i_rd_addr[k*NB_ADDR +: NB_ADDR] = a;
    endtask

    initial begin
        int n;
        ifa.i_enable       = 1'b1;
        ifa.i_dunit_clk_en = 1'b1;
        ifa.i_wb_we        = 1'b0;
        ifa.i_wb_addr      = '0;
        ifa.i_wb_data      = '0;
        ifa.i_rd_addr      = '0;
        ifa.i_dbg_addr     = '0;
        ifa.i_clear        = 1'b0;
        #1 chk_on = 1'b1;

        // Reset holds everything at zero whatever the addresses.
        for (int i = 0; i < 3; i++) begin
            ifa.i_rd_addr  = N_RD*NB_ADDR'($urandom);
            ifa.i_dbg_addr = NB_ADDR'($urandom);
            step();
            chk("rst_rd_a", ifa.o_rd_data[31:0], 32'd0);
            chk("rst_dbg_b", ifb.o_dbg_data, 32'd0);
            chk("rst_busy", 32'(ifa.o_busy), 32'd0);
        end
        rst_n = 1'b1;

        ifa.i_wb_we = 1'b1; ifa.i_wb_addr = 5'd5; ifa.i_wb_data = 32'hDEADBEEF;
        step();
        ifa.i_wb_we = 1'b0; set_rd(0, 5'd5); #1;
        chk("wr5_a", ifa.o_rd_data[31:0], 32'hDEADBEEF);
        chk("wr5_b", ifb.o_rd_data[31:0], 32'hDEADBEEF);

        ifa.i_wb_we = 1'b1; ifa.i_wb_addr = 5'd7; ifa.i_wb_data = 32'h12345678;
        set_rd(1, 5'd7); ifa.i_dbg_addr = 5'd7; #1;
        chk("byp_rd1_a", ifa.o_rd_data[63:32], 32'h12345678);
        chk("byp_rd1_b", ifb.o_rd_data[63:32], 32'd0);
        chk("byp_dbg_a", ifa.o_dbg_data, 32'd0);
        step();

        ifa.i_wb_addr = 5'd0; ifa.i_wb_data = 32'hFFFFFFFF;
        step();
        ifa.i_wb_we = 1'b0; set_rd(0, 5'd0); ifa.i_dbg_addr = 5'd0; #1;
        chk("r0_rd_a", ifa.o_rd_data[31:0], 32'd0);
        chk("r0_dbg_a", ifa.o_dbg_data, 32'd0);
        chk("r0_rd_b", ifb.o_rd_data[31:0], 32'hFFFFFFFF);
        chk("r0_dbg_b", ifb.o_dbg_data, 32'hFFFFFFFF);

        ifa.i_wb_we = 1'b1; ifa.i_wb_addr = 5'd3; ifa.i_wb_data = 32'hAA; ifa.i_enable = 1'b0;
        step();
        ifa.i_enable = 1'b1; ifa.i_dunit_clk_en = 1'b0;
        step();
        ifa.i_dunit_clk_en = 1'b1; ifa.i_wb_we = 1'b0; set_rd(0, 5'd3); #1;
        chk("gate_a", ifa.o_rd_data[31:0], 32'd0);
        chk("gate_b", ifb.o_rd_data[31:0], 32'd0);

        // Random traffic; read addresses often alias the write address to hit bypass.
        for (int i = 0; i < 600; i++) begin
            ifa.i_wb_we        = 1'($urandom);
            ifa.i_enable       = ($urandom % 8) != 0;
            ifa.i_dunit_clk_en = ($urandom % 6) != 0;
            ifa.i_wb_addr      = NB_ADDR'($urandom);
            ifa.i_wb_data      = $urandom;
            ifa.i_rd_addr      = N_RD*NB_ADDR'($urandom);
            if ($urandom % 3 == 0) set_rd(int'($urandom % N_RD), ifa.i_wb_addr);
            ifa.i_dbg_addr     = ($urandom % 3 == 0) ? ifa.i_wb_addr : NB_ADDR'($urandom);
            ifa.i_clear        = ($urandom % 50) == 0;
            if ($urandom % 200 == 0) begin
                ifa.i_wb_we = 1'b0;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                step();
            end
        end
        ifa.i_clear = 1'b0; ifa.i_wb_we = 1'b0; ifa.i_dunit_clk_en = 1'b1; ifa.i_enable = 1'b1;
        n = 0;
        while ((ifa.o_busy || ifa.o_clear_done) && n < 100) begin n++; step(); end
        chk("rand_drain", 32'(ifa.o_busy || ifa.o_clear_done), 32'd0);

        for (int i = 0; i < DEPTH; i++) begin
            ifa.i_wb_we = 1'b1; ifa.i_wb_addr = NB_ADDR'(i); ifa.i_wb_data = 32'(i + 1);
            step();
        end
        ifa.i_wb_we = 1'b0; ifa.i_clear = 1'b1;
        step();
        ifa.i_clear = 1'b0;
        n = 0;
        while (ifa.o_busy && n < 100) begin
            ifa.i_wb_we = (n == 5); ifa.i_wb_addr = 5'd20; ifa.i_wb_data = 32'h55;
            if (n == 5) begin
                set_rd(0, 5'd30); set_rd(1, 5'd2); #1;
                chk("midclr_rd30", ifa.o_rd_data[31:0], 32'd31);
                chk("midclr_rd2", ifa.o_rd_data[63:32], 32'd0);
            end
            n++;
            step();
        end
        ifa.i_wb_we = 1'b0;
        chk("clr_busy_len", 32'(n), 32'd32);
        chk("clr_done_hi", 32'(ifa.o_clear_done), 32'd1);
        set_rd(0, 5'd20); set_rd(1, 5'd31);
        step();
        chk("clr_done_lo", 32'(ifa.o_clear_done), 32'd0);
        chk("clr_drop20", ifa.o_rd_data[31:0], 32'd0);
        chk("clr_rd31", ifa.o_rd_data[63:32], 32'd0);

        ifa.i_clear = 1'b1;
        step();
        ifa.i_clear = 1'b0;
        n = 0;
        while (ifa.o_busy && n < 100) begin
            ifa.i_dunit_clk_en = !(n >= 10 && n < 15);
            n++;
            step();
        end
        ifa.i_dunit_clk_en = 1'b1;
        chk("pause_busy_len", 32'(n), 32'd37);
        step();

        ifa.i_clear = 1'b1;
        step();
        ifa.i_clear = 1'b0;
        repeat (10) step();
        chk("abort_busy_pre", 32'(ifa.o_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy_a", 32'(ifa.o_busy), 32'd0);
        chk("abort_busy_b", 32'(ifb.o_busy), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("abort_idle", 32'(ifa.o_busy || ifa.o_clear_done), 32'd0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
